// File: rtl/cp_inserter_pkg.sv
// Shared definitions for the cyclic prefix inserter: FSM encoding and
// settings-bus register offsets.
package cp_inserter_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_BODY   = 2'd2
  } state_t;

  localparam int unsigned SR_FRAME_LEN = 0;
  localparam int unsigned SR_GAP_LEN   = 1;

endpackage

// File: rtl/cp_ram.sv
// Simple dual-port symbol buffer: one write port, one synchronous read port
// whose output register only advances on a read and doubles as output hold.
module cp_ram #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cyclic_prefix_inserter.sv
// Buffers one OFDM symbol per input packet, then emits the last gap_len
// samples as a cyclic prefix followed by the whole symbol.
module cyclic_prefix_inserter #(
  parameter int BASE   = 0,
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tlast,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tlast,
  output logic             out_tvalid,
  input  logic             out_tready
);
  import cp_inserter_pkg::*;

  typedef logic [AWIDTH:0] len_t;
  localparam int unsigned MAXL = 2**AWIDTH;

  function automatic len_t clamp_frame(input logic [15:0] v);
    if (v == 16'd0)                   return len_t'(1);
    else if ({1'b0, v} > 17'(MAXL))   return len_t'(MAXL);
    else                              return len_t'(v);
  endfunction

  function automatic len_t min_gap(input logic [15:0] g, input len_t l);
    if ({1'b0, g} > 17'(l)) return l;
    else                    return len_t'(g);
  endfunction

  logic [15:0] frame_cfg, gap_cfg, gap_work;
  len_t        frame_work, wr_ptr, rd_ptr, len_q;
  len_t        cur_frame, wr_len, p_len, last_idx;
  logic [15:0] cur_gap;
  logic        rd_done, in_fire, sym_end, out_fire, re, last_rd;
  logic        unused_bits;
  state_t      state, state_d;

  assign unused_bits = ^set_data[31:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cfg <= '0;
      gap_cfg   <= '0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE + SR_FRAME_LEN)) frame_cfg <= set_data[15:0];
      if (set_addr == 8'(BASE + SR_GAP_LEN))   gap_cfg   <= set_data[15:0];
    end
  end

  // The first sample of a symbol sees the live settings; later samples use
  // the copies latched on that first handshake.
  assign cur_frame = (wr_ptr == '0) ? clamp_frame(frame_cfg) : frame_work;
  assign cur_gap   = (wr_ptr == '0) ? gap_cfg : gap_work;

  assign in_tready = (state == ST_FILL) && !reset;
  assign in_fire   = in_tready && in_tvalid;
  assign wr_len    = wr_ptr + 1'b1;
  assign sym_end   = in_fire && (in_tlast || (wr_len == cur_frame));
  assign p_len     = min_gap(cur_gap, wr_len);

  assign out_fire  = out_tvalid && out_tready;
  assign last_idx  = len_q - 1'b1;
  assign last_rd   = (rd_ptr == last_idx);
  assign re        = !clear && (!out_tvalid || out_tready) &&
                     ((state == ST_PREFIX) || ((state == ST_BODY) && !rd_done));

  always_comb begin
    state_d = state;
    case (state)
      ST_FILL:   if (sym_end) state_d = (p_len != '0) ? ST_PREFIX : ST_BODY;
      ST_PREFIX: if (re && last_rd) state_d = ST_BODY;
      ST_BODY:   if (out_fire && out_tlast) state_d = ST_FILL;
      default:   state_d = ST_FILL;
    endcase
    if (clear) state_d = ST_FILL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      len_q      <= '0;
      rd_done    <= 1'b0;
      frame_work <= '0;
      gap_work   <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else begin
      state <= state_d;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        rd_done    <= 1'b0;
        out_tvalid <= 1'b0;
      end else begin
        if (in_fire) begin
          if (wr_ptr == '0) begin
            frame_work <= cur_frame;
            gap_work   <= cur_gap;
          end
          if (sym_end) begin
            wr_ptr  <= '0;
            len_q   <= wr_len;
            rd_ptr  <= (p_len != '0) ? (wr_len - p_len) : '0;
            rd_done <= 1'b0;
          end else begin
            wr_ptr <= wr_len;
          end
        end
        if (re) begin
          out_tlast <= (state == ST_BODY) && last_rd;
          if (last_rd) begin
            rd_ptr <= '0;
            if (state == ST_BODY) rd_done <= 1'b1;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        if (re)              out_tvalid <= 1'b1;
        else if (out_tready) out_tvalid <= 1'b0;
      end
    end
  end

  cp_ram #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (in_fire && !clear),
    .waddr (wr_ptr[AWIDTH-1:0]),
    .wdata (in_tdata),
    .re    (re),
    .raddr (rd_ptr[AWIDTH-1:0]),
    .rdata (out_tdata)
  );

endmodule

// File: tb/tb_cyclic_prefix_inserter.sv
// Scoreboard bench for cyclic_prefix_inserter: directed symbols with
// hand-computed prefixed outputs, checked by an independent output monitor.
module tb_cyclic_prefix_inserter;

  logic        clk = 1'b0;
  logic        reset, clear, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] in_tdata;
  logic        in_tlast, in_tvalid, in_tready;
  logic [31:0] out_tdata;
  logic        out_tlast, out_tvalid, out_tready;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] held;
  bit held_valid = 1'b0;

  always #5 clk = ~clk;

  cyclic_prefix_inserter #(.BASE(0), .WIDTH(32), .AWIDTH(11)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle; a valid&ready here completes at the next edge.
  always @(negedge clk) begin
    if (out_tvalid) begin
      if (held_valid) begin
        checks++;
        if ({out_tlast, out_tdata} !== held) begin
          errors++;
          $display("FAIL stall_stable: got %0h expected %0h", {out_tlast, out_tdata}, held);
        end
      end
      if (out_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", {out_tlast, out_tdata});
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({out_tlast, out_tdata} !== e) begin
            errors++;
            $display("FAIL beat: got last=%0b data=%0d expected last=%0b data=%0d",
                     out_tlast, out_tdata, e[32], e[31:0]);
          end
        end
        held_valid = 1'b0;
      end else begin
        held = {out_tlast, out_tdata};
        held_valid = 1'b1;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_tready = ($urandom_range(0, 9) < 3);
  end

  task automatic exp_range(input int lo, input int hi, input bit last_on_hi);
    for (int v = lo; v <= hi; v++) exp_q.push_back({last_on_hi && (v == hi), 32'(v)});
  endtask

  task automatic write_setting(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic send(input int n, input int base, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      int t;
      in_tdata  = 32'(base + i);
      in_tlast  = last_at_end && (i == n - 1);
      in_tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_tready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) chk("in_tready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_tvalid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!out_tvalid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("out_tvalid_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    in_tdata = '0; in_tlast = 1'b0; in_tvalid = 1'b0; out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_tvalid", 64'(out_tvalid), 0);
    chk("rst_out_tlast",  64'(out_tlast), 0);
    chk("rst_out_tdata",  64'(out_tdata), 0);
    chk("rst_in_tready",  64'(in_tready), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // frame 8, gap 2: prefix 6,7 then 0..7; first valid two cycles after last input
    write_setting(8'd0, 32'd8);
    write_setting(8'd1, 32'd2);
    exp_range(6, 7, 1'b0);
    exp_range(0, 7, 1'b1);
    send(8, 0, 1'b1);
    @(negedge clk);
    chk("latency_cycle1_valid", 64'(out_tvalid), 0);
    @(negedge clk);
    chk("latency_cycle2_valid", 64'(out_tvalid), 1);
    @(posedge clk); #1;
    drain("drain_gap2");

    // gap 0: body only; in_tready back the cycle after the final handshake
    write_setting(8'd1, 32'd0);
    exp_range(0, 7, 1'b1);
    send(8, 0, 1'b1);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!(out_tvalid && out_tready && out_tlast) && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("final_beat_seen", 64'(t < 200), 1);
      chk("in_tready_during_body", 64'(in_tready), 0);
      @(negedge clk);
      chk("in_tready_after_final", 64'(in_tready), 1);
    end
    @(posedge clk); #1;
    drain("drain_gap0");

    // short symbol by tlast
    write_setting(8'd1, 32'd2);
    exp_range(2, 3, 1'b0);
    exp_range(0, 3, 1'b1);
    send(4, 0, 1'b1);
    drain("drain_short");

    // prefix clamped to symbol length
    write_setting(8'd1, 32'd10);
    exp_range(0, 7, 1'b0);
    exp_range(0, 7, 1'b1);
    send(8, 0, 1'b1);
    drain("drain_clamped");

    // frame 4, gap 1, no tlast: three symbols split by frame_len
    write_setting(8'd0, 32'd4);
    write_setting(8'd1, 32'd1);
    for (int s = 0; s < 3; s++) begin
      exp_range(4*s + 3, 4*s + 3, 1'b0);
      exp_range(4*s, 4*s + 3, 1'b1);
    end
    send(12, 0, 1'b0);
    drain("drain_framed");

    // frame 64, gap 16 with random backpressure
    write_setting(8'd0, 32'd64);
    write_setting(8'd1, 32'd16);
    exp_range(1048, 1063, 1'b0);
    exp_range(1000, 1063, 1'b1);
    rand_ready = 1'b1;
    send(64, 1000, 1'b1);
    drain("drain_backpressure");
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_tready = 1'b1;

    // clear mid-body after exactly four accepted beats
    write_setting(8'd0, 32'd8);
    write_setting(8'd1, 32'd2);
    out_tready = 1'b0;
    exp_q.push_back({1'b0, 32'd106});
    exp_q.push_back({1'b0, 32'd107});
    exp_q.push_back({1'b0, 32'd100});
    exp_q.push_back({1'b0, 32'd101});
    send(8, 100, 1'b1);
    wait_out_valid();
    @(posedge clk); #1;
    out_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    out_tready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_drops_valid", 64'(out_tvalid), 0);
    chk("clear_beats_consumed", 64'(exp_q.size()), 0);
    @(posedge clk); #1;
    out_tready = 1'b1;
    exp_range(6, 7, 1'b0);
    exp_range(0, 7, 1'b1);
    send(8, 0, 1'b1);
    drain("drain_after_clear");

    // async reset during the prefix
    out_tready = 1'b0;
    send(8, 200, 1'b1);
    wait_out_valid();
    #2;
    reset = 1'b1;
    #1;
    chk("areset_out_tvalid", 64'(out_tvalid), 0);
    chk("areset_out_tdata",  64'(out_tdata), 0);
    chk("areset_out_tlast",  64'(out_tlast), 0);
    chk("areset_in_tready",  64'(in_tready), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    out_tready = 1'b1;
    @(posedge clk); #1;
    write_setting(8'd0, 32'd8);
    write_setting(8'd1, 32'd2);
    exp_range(6, 7, 1'b0);
    exp_range(0, 7, 1'b1);
    send(8, 0, 1'b1);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
